// File: rtl/segre_miss_arbiter.sv
// Miss arbiter: round-robin grant between dcache and icache refill requests onto a
// single lane-wide memory port, with dirty victim write-back ahead of a dcache refill.
module segre_miss_arbiter #(
  parameter int ADDR_SIZE   = 32,
  parameter int LANE_SIZE   = 128,
  parameter int OFFSET_BITS = $clog2(LANE_SIZE / 8)
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  // dcache side
  input  logic                 dc_miss_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  input  logic                 dc_wb_i,
  input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
  input  logic [LANE_SIZE-1:0] dc_wb_data_i,
  output logic                 dc_data_rdy_o,
  output logic [ADDR_SIZE-1:0] dc_addr_o,
  output logic [LANE_SIZE-1:0] dc_data_o,
  // icache side
  input  logic                 ic_miss_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_data_rdy_o,
  output logic [ADDR_SIZE-1:0] ic_addr_o,
  output logic [LANE_SIZE-1:0] ic_data_o,
  // memory side
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LANE_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [LANE_SIZE-1:0] mem_rdata_i,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_DC,
    RD_IC,
    RESP
  } state_e;

  typedef enum logic {
    GNT_DC,
    GNT_IC
  } gnt_e;

  state_e               state_q,      state_d;
  gnt_e                 last_grant_q, last_grant_d;
  logic [ADDR_SIZE-1:0] rd_addr_q,    rd_addr_d;
  logic [ADDR_SIZE-1:0] wb_addr_q,    wb_addr_d;
  logic [LANE_SIZE-1:0] wb_data_q,    wb_data_d;
  logic [ADDR_SIZE-1:0] dc_addr_q,    dc_addr_d;
  logic [LANE_SIZE-1:0] dc_data_q,    dc_data_d;
  logic [ADDR_SIZE-1:0] ic_addr_q,    ic_addr_d;
  logic [LANE_SIZE-1:0] ic_data_q,    ic_data_d;

  logic grant_dc;
  logic grant_ic;

  function automatic logic [ADDR_SIZE-1:0] lane_align(input logic [ADDR_SIZE-1:0] addr);
    return {addr[ADDR_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

  // On a conflict the requester not granted last wins; last_grant starts at IC.
  always_comb begin
    grant_dc = (state_q == IDLE) && dc_miss_i && (!ic_miss_i || (last_grant_q == GNT_IC));
    grant_ic = (state_q == IDLE) && ic_miss_i && !grant_dc;
  end

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  // NOTE: state_d gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_dc)      state_d = dc_wb_i ? WB : RD_DC;
        else if (grant_ic) state_d = RD_IC;
      end
      WB:      if (mem_rvalid_i) state_d = RD_DC;
      RD_DC:   if (mem_rvalid_i) state_d = RESP;
      RD_IC:   if (mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    dc_data_rdy_o = 1'b0;
    ic_data_rdy_o = 1'b0;
    busy_o        = (state_q != IDLE);
    unique case (state_q)
      WB: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = wb_addr_q;
        mem_wdata_o = wb_data_q;
      end
      RD_DC, RD_IC: begin
        mem_req_o  = 1'b1;
        mem_addr_o = rd_addr_q;
      end
      RESP: begin
        dc_data_rdy_o = (last_grant_q == GNT_DC);
        ic_data_rdy_o = (last_grant_q == GNT_IC);
      end
      default: ;
    endcase
  end

  assign dc_addr_o = dc_addr_q;
  assign dc_data_o = dc_data_q;
  assign ic_addr_o = ic_addr_q;
  assign ic_data_o = ic_data_q;

  // ---------------------------------------------------------------- datapath
  // Grant-time latches freeze request addresses and victim data; a late change on
  // the request inputs cannot disturb a transaction in flight.
  always_comb begin
    last_grant_d = last_grant_q;
    rd_addr_d    = rd_addr_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    dc_addr_d    = dc_addr_q;
    dc_data_d    = dc_data_q;
    ic_addr_d    = ic_addr_q;
    ic_data_d    = ic_data_q;

    if (grant_dc) begin
      last_grant_d = GNT_DC;
      rd_addr_d    = lane_align(dc_addr_i);
      wb_addr_d    = lane_align(dc_wb_addr_i);
      wb_data_d    = dc_wb_data_i;
    end else if (grant_ic) begin
      last_grant_d = GNT_IC;
      rd_addr_d    = lane_align(ic_addr_i);
    end

    if (mem_rvalid_i && (state_q == RD_DC)) begin
      dc_addr_d = rd_addr_q;
      dc_data_d = mem_rdata_i;
    end
    if (mem_rvalid_i && (state_q == RD_IC)) begin
      ic_addr_d = rd_addr_q;
      ic_data_d = mem_rdata_i;
    end
  end

  // NOTE: the lane data registers are reset as well, because every output,
  // including the returned refill lanes, must read zero while rsn_i is low.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      last_grant_q <= GNT_IC;
      rd_addr_q    <= '0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      dc_addr_q    <= '0;
      dc_data_q    <= '0;
      ic_addr_q    <= '0;
      ic_data_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_addr_q    <= rd_addr_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      dc_addr_q    <= dc_addr_d;
      dc_data_q    <= dc_data_d;
      ic_addr_q    <= ic_addr_d;
      ic_data_q    <= ic_data_d;
    end
  end

endmodule

// File: tb/tb_segre_miss_arbiter.sv
// Directed bench for segre_miss_arbiter: inputs driven and outputs sampled on the
// falling clock edge, expected values written out by hand.
module tb_segre_miss_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  localparam logic [LW-1:0] D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [LW-1:0] V2 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_1234_5678;
  localparam logic [LW-1:0] D2 = 128'hA5A5_A5A5_0202_0202_5A5A_5A5A_2020_2020;
  localparam logic [LW-1:0] D3 = 128'h0000_0000_0000_0000_0000_0000_0000_0033;
  localparam logic [LW-1:0] D4 = 128'h4444_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [LW-1:0] D5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
  localparam logic [LW-1:0] D6 = 128'h6666_0000_6666_0000_6666_0000_6666_0000;
  localparam logic [LW-1:0] D7 = 128'h7777_7777_0000_0000_7777_7777_0000_0000;
  localparam logic [LW-1:0] JK = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
  localparam logic [LW-1:0] D8 = 128'h8888_0000_0000_0000_0000_0000_0000_8888;

  logic          clk_i = 1'b0;
  logic          rsn_i;
  logic          dc_miss_i, dc_wb_i, ic_miss_i, mem_rvalid_i;
  logic [AW-1:0] dc_addr_i, dc_wb_addr_i, ic_addr_i;
  logic [LW-1:0] dc_wb_data_i, mem_rdata_i;
  logic          dc_data_rdy_o, ic_data_rdy_o, mem_req_o, mem_we_o, busy_o;
  logic [AW-1:0] dc_addr_o, ic_addr_o, mem_addr_o;
  logic [LW-1:0] dc_data_o, ic_data_o, mem_wdata_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  segre_miss_arbiter #(.ADDR_SIZE(AW), .LANE_SIZE(LW)) dut (
    .clk_i        (clk_i),
    .rsn_i        (rsn_i),
    .dc_miss_i    (dc_miss_i),
    .dc_addr_i    (dc_addr_i),
    .dc_wb_i      (dc_wb_i),
    .dc_wb_addr_i (dc_wb_addr_i),
    .dc_wb_data_i (dc_wb_data_i),
    .dc_data_rdy_o(dc_data_rdy_o),
    .dc_addr_o    (dc_addr_o),
    .dc_data_o    (dc_data_o),
    .ic_miss_i    (ic_miss_i),
    .ic_addr_i    (ic_addr_i),
    .ic_data_rdy_o(ic_data_rdy_o),
    .ic_addr_o    (ic_addr_o),
    .ic_data_o    (ic_data_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rsn_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rsn_i = 1'b1;
  endtask

  // Wait (bounded) for a memory request, check it, then return rvalid after lat cycles.
  // Leaves the bench at the falling edge of the cycle after rvalid was sampled.
  task automatic serve(input string tag, input logic exp_we, input logic [AW-1:0] exp_addr,
                       input logic [LW-1:0] exp_wdata, input int lat, input logic [LW-1:0] rdata);
    int waited = 0;
    while (!mem_req_o && waited < 20) begin
      @(negedge clk_i);
      waited++;
    end
    check({tag, "_req"}, LW'(mem_req_o), LW'(1'b1));
    check({tag, "_we"}, LW'(mem_we_o), LW'(exp_we));
    check({tag, "_addr"}, LW'(mem_addr_o), LW'(exp_addr));
    if (exp_we) check({tag, "_wdata"}, mem_wdata_o, exp_wdata);
    repeat (lat - 1) @(negedge clk_i);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  initial begin
    rsn_i = 1'b0; dc_miss_i = 1'b0; dc_wb_i = 1'b0; ic_miss_i = 1'b0; mem_rvalid_i = 1'b0;
    dc_addr_i = '0; dc_wb_addr_i = '0; ic_addr_i = '0; dc_wb_data_i = '0; mem_rdata_i = '0;
    @(negedge clk_i);
    check("rst_busy", LW'(busy_o), '0);
    check("rst_req", LW'(mem_req_o), '0);
    check("rst_dc_addr", LW'(dc_addr_o), '0);
    reset_dut();

    // Single icache miss, latency 4
    ic_miss_i = 1'b1; ic_addr_i = 32'h0000_1234;
    @(negedge clk_i);
    check("t1_req_next", LW'(mem_req_o), LW'(1'b1));
    serve("t1", 1'b0, 32'h0000_1230, '0, 4, D1);
    check("t1_rdy", LW'(ic_data_rdy_o), LW'(1'b1));
    check("t1_dc_rdy", LW'(dc_data_rdy_o), '0);
    check("t1_addr_o", LW'(ic_addr_o), LW'(32'h0000_1230));
    check("t1_data_o", ic_data_o, D1);
    check("t1_req_resp", LW'(mem_req_o), '0);
    ic_miss_i = 1'b0;
    @(negedge clk_i);
    check("t1_rdy_pulse", LW'(ic_data_rdy_o), '0);
    check("t1_idle", LW'(busy_o), '0);

    // Dcache miss with dirty victim: write-back then refill, no req gap
    dc_miss_i = 1'b1; dc_addr_i = 32'h0000_2008; dc_wb_i = 1'b1;
    dc_wb_addr_i = 32'h0000_8040; dc_wb_data_i = V2;
    @(negedge clk_i);
    dc_wb_i = 1'b0;
    serve("t2_wb", 1'b1, 32'h0000_8040, V2, 2, JK);
    check("t2_nogap", LW'(mem_req_o), LW'(1'b1));
    check("t2_rd_we", LW'(mem_we_o), '0);
    serve("t2_rd", 1'b0, 32'h0000_2000, '0, 1, D2);
    check("t2_rdy", LW'(dc_data_rdy_o), LW'(1'b1));
    check("t2_ic_rdy", LW'(ic_data_rdy_o), '0);
    check("t2_addr_o", LW'(dc_addr_o), LW'(32'h0000_2000));
    check("t2_data_o", dc_data_o, D2);
    dc_miss_i = 1'b0;
    @(negedge clk_i);
    check("t2_rdy_pulse", LW'(dc_data_rdy_o), '0);

    // Simultaneous requests after reset: dcache first, then round-robin to icache
    reset_dut();
    dc_miss_i = 1'b1; dc_addr_i = 32'h0000_3004;
    ic_miss_i = 1'b1; ic_addr_i = 32'h0000_4008;
    @(negedge clk_i);
    serve("t3_dc", 1'b0, 32'h0000_3000, '0, 1, D3);
    check("t3_dc_rdy", LW'(dc_data_rdy_o), LW'(1'b1));
    check("t3_dc_ic_rdy", LW'(ic_data_rdy_o), '0);
    dc_addr_i = 32'h0000_5010;  // dcache issues a fresh miss, conflicting again
    @(negedge clk_i);
    check("t3_gap", LW'(mem_req_o), '0);
    @(negedge clk_i);
    serve("t3_ic", 1'b0, 32'h0000_4000, '0, 2, D4);
    check("t3_ic_rdy", LW'(ic_data_rdy_o), LW'(1'b1));
    check("t3_ic_data", ic_data_o, D4);
    ic_miss_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    serve("t3_dc2", 1'b0, 32'h0000_5010, '0, 1, D5);
    check("t3_dc2_rdy", LW'(dc_data_rdy_o), LW'(1'b1));
    check("t3_dc2_data", dc_data_o, D5);
    dc_miss_i = 1'b0;
    @(negedge clk_i);

    // Icache request mid-dcache refill, dcache address changes after grant
    dc_miss_i = 1'b1; dc_addr_i = 32'h0000_6020;
    @(negedge clk_i);
    ic_miss_i = 1'b1; ic_addr_i = 32'h0000_7000; dc_addr_i = 32'h0000_9990;
    @(negedge clk_i);
    serve("t4_dc", 1'b0, 32'h0000_6020, '0, 2, D6);
    check("t4_dc_rdy", LW'(dc_data_rdy_o), LW'(1'b1));
    check("t4_dc_addr_o", LW'(dc_addr_o), LW'(32'h0000_6020));
    check("t4_ic_rdy", LW'(ic_data_rdy_o), '0);
    dc_miss_i = 1'b0;
    @(negedge clk_i);
    check("t4_idle_req", LW'(mem_req_o), '0);
    check("t4_idle_busy", LW'(busy_o), '0);
    @(negedge clk_i);
    serve("t4_ic", 1'b0, 32'h0000_7000, '0, 1, D7);
    check("t4_ic_rdy2", LW'(ic_data_rdy_o), LW'(1'b1));
    check("t4_ic_data", ic_data_o, D7);
    ic_miss_i = 1'b0;
    @(negedge clk_i);

    // Asynchronous reset while in RD_DC
    dc_miss_i = 1'b1; dc_addr_i = 32'h0000_A000;
    ic_miss_i = 1'b1; ic_addr_i = 32'h0000_B000;
    @(negedge clk_i);
    check("t5_rd_addr", LW'(mem_addr_o), LW'(32'h0000_A000));
    #2 rsn_i = 1'b0;
    #1;
    check("t5_req", LW'(mem_req_o), '0);
    check("t5_addr", LW'(mem_addr_o), '0);
    check("t5_busy", LW'(busy_o), '0);
    check("t5_dc_addr_o", LW'(dc_addr_o), '0);
    check("t5_ic_data_o", ic_data_o, '0);
    dc_miss_i = 1'b0;
    @(negedge clk_i);
    rsn_i = 1'b1;
    @(negedge clk_i);
    serve("t5_ic", 1'b0, 32'h0000_B000, '0, 1, D7);
    check("t5_ic_rdy", LW'(ic_data_rdy_o), LW'(1'b1));
    check("t5_ic_data", ic_data_o, D7);
    ic_miss_i = 1'b0;
    @(negedge clk_i);

    // Stray rvalid in IDLE coinciding with a new icache miss
    mem_rvalid_i = 1'b1; mem_rdata_i = JK;
    ic_miss_i = 1'b1; ic_addr_i = 32'h0000_C00C;
    @(negedge clk_i);
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    check("t6_no_rdy", LW'(ic_data_rdy_o), '0);
    check("t6_no_cap", ic_data_o, D7);
    serve("t6_ic", 1'b0, 32'h0000_C000, '0, 2, D8);
    check("t6_rdy", LW'(ic_data_rdy_o), LW'(1'b1));
    check("t6_data", ic_data_o, D8);
    check("t6_addr_o", LW'(ic_addr_o), LW'(32'h0000_C000));
    ic_miss_i = 1'b0;
    @(negedge clk_i);
    check("t6_end_busy", LW'(busy_o), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/segre_miss_arbiter.md
# segre_miss_arbiter

Sequences cache-line refills and dirty write-backs between the data-cache tag/lookup stage and the instruction fetch cache on one side, and the single shared memory port on the other. It accepts level-held miss requests from both caches and grants them round-robin. It runs at most one memory transaction at a time and returns each refilled lane with its line address and a one-cycle data-ready pulse. The data-cache requester also drives the pipeline hazard release, so the data-ready pulse is what un-stalls the TL stage.

## Interface
- ADDR_SIZE, 32, byte address width.
- LANE_SIZE, 128, cache lane width in bits (equals DCACHE_LANE_SIZE); must be a power of two ≥ 8.
- OFFSET_BITS, $clog2(LANE_SIZE/8), derived; lane byte-offset width.

- clk_i  in  1  clock; all state updates on rising edge.
- rsn_i  in  1  reset, asynchronous, active-low.
- dc_miss_i  in  1  dcache refill request, held high until dc_data_rdy_o.
- dc_addr_i  in  ADDR_SIZE  dcache miss address (any byte in the lane).
- dc_wb_i  in  1  victim lane is dirty; write back before refill; sampled with dc_miss_i.
- dc_wb_addr_i  in  ADDR_SIZE  victim lane address.
- dc_wb_data_i  in  LANE_SIZE  victim lane data.
- dc_data_rdy_o  out  1  one-cycle refill-complete pulse to dcache.
- dc_addr_o  out  ADDR_SIZE  lane-aligned refill address.
- dc_data_o  out  LANE_SIZE  refill data.
- ic_miss_i  in  1  icache refill request, held high until ic_data_rdy_o.
- ic_addr_i  in  ADDR_SIZE  icache miss address.
- ic_data_rdy_o  out  1  one-cycle refill-complete pulse to icache.
- ic_addr_o  out  ADDR_SIZE  lane-aligned refill address.
- ic_data_o  out  LANE_SIZE  refill data.
- mem_req_o  out  1  memory transaction active.
- mem_we_o  out  1  1 = lane write, 0 = lane read.
- mem_addr_o  out  ADDR_SIZE  lane-aligned address; low OFFSET_BITS are always 0.
- mem_wdata_o  out  LANE_SIZE  write data; valid while mem_we_o = 1.
- mem_rvalid_i  in  1  one-cycle completion; ends the current transaction (read or write).
- mem_rdata_i  in  LANE_SIZE  read data, valid with mem_rvalid_i on reads.
- busy_o  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, WB, RD_DC, RD_IC, RESP.
- In IDLE the block samples dc_miss_i and ic_miss_i.
  - Only one request pending: grant it.
  - Both pending: grant the requester not granted last. The last_grant register resets to IC, so the dcache wins the first conflict.
- At grant the block latches the following:
  - the requester's aligned address;
  - for dcache only, dc_wb_i, the aligned dc_wb_addr_i and dc_wb_data_i.
  - last_grant is updated at grant.
- Dcache grant with dc_wb_i = 1 goes to WB; otherwise to RD_DC. Icache grant goes to RD_IC.
- WB: mem_req_o = 1, mem_we_o = 1, mem_addr_o = latched victim address, mem_wdata_o = latched victim data. On mem_rvalid_i the FSM goes to RD_DC.
- RD_DC / RD_IC: mem_req_o = 1, mem_we_o = 0, mem_addr_o = latched refill address. On mem_rvalid_i, mem_rdata_i is captured into the granted requester's data register and the FSM goes to RESP.
- RESP: the granted requester's data_rdy_o = 1 for exactly this cycle, with addr_o/data_o valid. Next state is IDLE.
- Requesters must deassert miss_i in the cycle after data_rdy_o. A miss_i still high in IDLE is treated as a new request.
- addr_o/data_o hold their last value until the next refill for that requester.
- Request inputs are ignored outside IDLE. Address changes after grant have no effect.
- mem_rvalid_i outside WB/RD_DC/RD_IC is ignored.

## Timing
- All outputs are registered (from FSM/state registers); there are no combinational input-to-output paths.
- Reset (asynchronous, any time including mid-transaction):
  - state = IDLE, last_grant = IC;
  - all outputs 0 (mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, both rdy/addr/data, busy_o);
  - any in-flight transaction is abandoned; the memory is reset by the same rsn_i.
- Miss sampled high in IDLE at edge k → mem_req_o = 1 from cycle k+1.
- mem_rvalid_i high at edge m (read state) → data_rdy_o = 1 in cycle m+1. Minimum miss-to-rdy is 3 cycles (rvalid in the first request cycle).
- WB → read has no gap: mem_req_o stays 1 while mem_we_o drops and mem_addr_o changes in the cycle after the write's rvalid. Memory treats each rvalid as the end of one transaction.
- mem_req_o falls in the RESP cycle. The earliest next grant is the IDLE cycle after RESP, so there is a minimum of 2 non-request cycles between refills.

## Test plan
- Single icache miss, addr 0x0000_1234, memory latency 4 (rvalid 4 cycles after mem_req_o rises) →
  - mem_addr_o = 0x0000_1230, mem_we_o = 0;
  - ic_data_rdy_o pulses 1 cycle, one cycle after rvalid;
  - ic_data_o = mem_rdata_i, ic_addr_o = 0x0000_1230.
- Dcache miss with dc_wb_i = 1, victim 0x0000_8040, refill 0x0000_2008 →
  - write to 0x0000_8040 with wdata = victim data;
  - then, with no mem_req_o gap, a read of 0x0000_2000;
  - dc_data_rdy_o pulses once; ic_data_rdy_o stays 0.
- Both misses asserted in the same cycle after reset →
  - dcache served first, then icache;
  - on the next simultaneous pair, icache served first.
- A new icache request arrives mid-dcache refill, and dc_addr_i changes after grant →
  - the dcache transaction completes with the original latched address;
  - the icache is granted only after RESP → IDLE.
- rsn_i asserted while in RD_DC with mem_req_o = 1 →
  - all outputs 0 immediately (asynchronously);
  - after release, a pending ic_miss_i is granted with last_grant = IC semantics.
- mem_rvalid_i pulsed in IDLE, then a miss sampled in the same cycle →
  - the stray rvalid causes no rdy pulse and no data capture;
  - the later transaction completes normally.
